// File: rtl/memory_stage.sv
// MEM stage of the 5-stage pipeline: registers EX results, runs the variable-latency
// data-memory handshake, aligns/extends loads, builds store enables, and feeds WB.
module memory_stage #(
    parameter logic [0:5] NOP_OPCODE = 6'h15,
    parameter int         DW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [0:DW-1] InALUOut,
    input  logic [0:DW-1] InFPUOut,
    input  logic [0:DW-1] InStoreData,
    input  logic [0:5]    InOpcode,
    input  logic [0:5]    InFunct,
    input  logic [0:DW-1] InPCPlusFour,
    input  logic [0:15]   InImmediate,
    input  logic [0:1]    InDInSrc,
    input  logic          InRegWE,
    input  logic [0:5]    InRegWAddr,
    input  logic          InMemRead,
    input  logic          InMemWrite,
    input  logic [0:1]    InMemSize,
    input  logic          InMemSigned,
    output logic          Busy,
    output logic          MisalignedErr,
    output logic          DMemReq,
    output logic          DMemWE,
    output logic [0:DW-1] DMemAddr,
    output logic [0:3]    DMemBE,
    output logic [0:DW-1] DMemWData,
    input  logic [0:DW-1] DMemRData,
    input  logic          DMemAck,
    output logic [0:DW-1] NextALUOut,
    output logic [0:DW-1] NextFPUOut,
    output logic [0:DW-1] NextMEMDout,
    output logic [0:5]    NextOpcode,
    output logic [0:5]    NextFunct,
    output logic [0:DW-1] NextPCPlusFour,
    output logic [0:15]   NextImmediate,
    output logic [0:1]    NextDInSrc,
    output logic          NextRegWE,
    output logic [0:5]    NextRegWAddr
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [0:1] SZ_BYTE = 2'b00;
    localparam logic [0:1] SZ_HALF = 2'b01;

    state_t        state;
    logic [0:DW-1] alu_q;
    logic [0:DW-1] fpu_q;
    logic [0:DW-1] store_q;
    logic [0:5]    opcode_q;
    logic [0:5]    funct_q;
    logic [0:DW-1] pc4_q;
    logic [0:15]   imm_q;
    logic [0:1]    din_src_q;
    logic          reg_we_q;
    logic [0:5]    reg_waddr_q;
    logic          mem_read_q;
    logic          mem_write_q;
    logic [0:1]    mem_size_q;
    logic          mem_signed_q;

    logic          in_mem;
    logic          in_misaligned;
    logic          in_access;
    logic          stall_bubble;
    logic [0:1]    off;
    logic [0:7]    ld_byte;
    logic [0:15]   ld_half;
    logic [0:DW-1] load_data;
    logic [0:3]    store_be;
    logic [0:DW-1] store_wdata;

    // Word-sized checks also cover the unused size code 11.
    assign in_mem        = InMemRead | InMemWrite;
    assign in_misaligned = in_mem &
                           (((InMemSize == SZ_HALF) & InALUOut[DW-1]) |
                            (InMemSize[0] & (InALUOut[DW-2:DW-1] != 2'b00)));

    assign in_access    = (state == ACCESS);
    assign stall_bubble = in_access & ~DMemAck;
    assign Busy         = stall_bubble;
    assign off          = alu_q[DW-2:DW-1];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ld_byte = DMemRData[0:7];
        case (off)
            2'd1:    ld_byte = DMemRData[8:15];
            2'd2:    ld_byte = DMemRData[16:23];
            2'd3:    ld_byte = DMemRData[24:31];
            default: ld_byte = DMemRData[0:7];
        endcase
        ld_half = off[0] ? DMemRData[16:31] : DMemRData[0:15];

        case (mem_size_q)
            SZ_BYTE: load_data = {{24{mem_signed_q & ld_byte[0]}}, ld_byte};
            SZ_HALF: load_data = {{16{mem_signed_q & ld_half[0]}}, ld_half};
            default: load_data = DMemRData;
        endcase
    end

    always_comb begin
        store_be    = 4'b1111;
        store_wdata = store_q;
        case (mem_size_q)
            SZ_BYTE: begin
                store_be    = 4'b1000 >> off;
                store_wdata = {4{store_q[24:31]}};
            end
            SZ_HALF: begin
                store_be    = off[0] ? 4'b0011 : 4'b1100;
                store_wdata = {2{store_q[16:31]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = store_q;
            end
        endcase
    end

    assign DMemReq   = in_access;
    assign DMemWE    = in_access & mem_write_q;
    assign DMemAddr  = {alu_q[0:DW-3], 2'b00};
    assign DMemBE    = in_access ? (mem_read_q ? 4'b1111 : store_be) : 4'b0000;
    assign DMemWData = store_wdata;

    // While stalled, WB still registers every cycle, so present a non-writing NOP.
    assign NextALUOut     = alu_q;
    assign NextFPUOut     = fpu_q;
    assign NextMEMDout    = (mem_read_q & in_access & DMemAck) ? load_data : '0;
    assign NextOpcode     = stall_bubble ? NOP_OPCODE : opcode_q;
    assign NextFunct      = funct_q;
    assign NextPCPlusFour = pc4_q;
    assign NextImmediate  = imm_q;
    assign NextDInSrc     = din_src_q;
    assign NextRegWE      = reg_we_q & ~stall_bubble;
    assign NextRegWAddr   = reg_waddr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            MisalignedErr <= 1'b0;
            alu_q         <= '0;
            fpu_q         <= '0;
            store_q       <= '0;
            opcode_q      <= NOP_OPCODE;
            funct_q       <= '0;
            pc4_q         <= '0;
            imm_q         <= '0;
            din_src_q     <= '0;
            reg_we_q      <= 1'b0;
            reg_waddr_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_size_q    <= '0;
            mem_signed_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            MisalignedErr <= 1'b0;
            if (in_access && DMemAck)
                state <= IDLE;

            // The ack cycle also captures, so a following mem op re-enters ACCESS directly.
            if (!Busy) begin
                alu_q         <= InALUOut;
                fpu_q         <= InFPUOut;
                store_q       <= InStoreData;
                opcode_q      <= InOpcode;
                funct_q       <= InFunct;
                pc4_q         <= InPCPlusFour;
                imm_q         <= InImmediate;
                din_src_q     <= InDInSrc;
                reg_we_q      <= InRegWE & ~in_misaligned;
                reg_waddr_q   <= InRegWAddr;
                mem_read_q    <= InMemRead & ~in_misaligned;
                mem_write_q   <= InMemWrite & ~in_misaligned;
                mem_size_q    <= InMemSize;
                mem_signed_q  <= InMemSigned;
                MisalignedErr <= in_misaligned;
                if (in_mem && !in_misaligned)
                    state <= ACCESS;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, random ops against a
// behavioural memory-access model, and a reset-during-access sequence.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InALUOut, InFPUOut, InStoreData, InPCPlusFour;
    logic [5:0]  InOpcode, InFunct, InRegWAddr;
    logic [15:0] InImmediate;
    logic [1:0]  InDInSrc, InMemSize;
    logic        InRegWE, InMemRead, InMemWrite, InMemSigned;
    logic        Busy, MisalignedErr, DMemReq, DMemWE, DMemAck;
    logic [31:0] DMemAddr, DMemWData, DMemRData;
    logic [3:0]  DMemBE;
    logic [31:0] NextALUOut, NextFPUOut, NextMEMDout, NextPCPlusFour;
    logic [5:0]  NextOpcode, NextFunct, NextRegWAddr;
    logic [15:0] NextImmediate;
    logic [1:0]  NextDInSrc;
    logic        NextRegWE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .reset(reset),
        .InALUOut(InALUOut), .InFPUOut(InFPUOut), .InStoreData(InStoreData),
        .InOpcode(InOpcode), .InFunct(InFunct), .InPCPlusFour(InPCPlusFour),
        .InImmediate(InImmediate), .InDInSrc(InDInSrc), .InRegWE(InRegWE),
        .InRegWAddr(InRegWAddr), .InMemRead(InMemRead), .InMemWrite(InMemWrite),
        .InMemSize(InMemSize), .InMemSigned(InMemSigned),
        .Busy(Busy), .MisalignedErr(MisalignedErr), .DMemReq(DMemReq), .DMemWE(DMemWE),
        .DMemAddr(DMemAddr), .DMemBE(DMemBE), .DMemWData(DMemWData),
        .DMemRData(DMemRData), .DMemAck(DMemAck),
        .NextALUOut(NextALUOut), .NextFPUOut(NextFPUOut), .NextMEMDout(NextMEMDout),
        .NextOpcode(NextOpcode), .NextFunct(NextFunct), .NextPCPlusFour(NextPCPlusFour),
        .NextImmediate(NextImmediate), .NextDInSrc(NextDInSrc), .NextRegWE(NextRegWE),
        .NextRegWAddr(NextRegWAddr)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [1:0]  size;
        logic        sgn;
        logic        rd;
        logic        wr;
        logic        we;
        logic [31:0] rdata;
        int          lat;
        logic        mis;
        logic        req;
        logic        dwe;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] dout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] sdata,
                                input logic [1:0] size, input logic sgn, input logic rd,
                                input logic wr, input logic we, input logic [31:0] rdata,
                                input int lat, input logic mis, input logic req,
                                input logic dwe, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] dout);
        vec_t v;
        v.alu = alu; v.sdata = sdata; v.size = size; v.sgn = sgn; v.rd = rd; v.wr = wr;
        v.we = we; v.rdata = rdata; v.lat = lat; v.mis = mis; v.req = req; v.dwe = dwe;
        v.addr = addr; v.be = be; v.wdata = wdata; v.dout = dout;
        return v;
    endfunction

    // Reference: byte offsets counted from the most significant byte (big-endian lanes).
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          off;
        logic [31:0] x;
        r     = v;
        off   = int'(v.alu[1:0]);
        r.mis = (v.rd || v.wr) && ((v.size == 2'd1 && (off % 2) == 1) || (v.size == 2'd2 && off != 0));
        r.req = (v.rd || v.wr) && !r.mis;
        r.dwe = r.req && v.wr;
        r.addr = v.alu - 32'(off);
        case (v.size)
            2'd0: begin
                r.be    = 4'(8 >> off);
                r.wdata = 32'(v.sdata[7:0]) * 32'h0101_0101;
            end
            2'd1: begin
                r.be    = (off < 2) ? 4'hC : 4'h3;
                r.wdata = 32'(v.sdata[15:0]) * 32'h0001_0001;
            end
            default: begin
                r.be    = 4'hF;
                r.wdata = v.sdata;
            end
        endcase
        if (v.rd) r.be = 4'hF;
        x = 32'h0;
        if (v.rd && r.req) begin
            case (v.size)
                2'd0: begin
                    x = (v.rdata >> (8 * (3 - off))) & 32'hFF;
                    if (v.sgn && x >= 32'd128) x = x - 32'd256;
                end
                2'd1: begin
                    x = (v.rdata >> (16 * (1 - off / 2))) & 32'hFFFF;
                    if (v.sgn && x >= 32'd32768) x = x - 32'd65536;
                end
                default: x = v.rdata;
            endcase
        end
        r.dout = x;
        return r;
    endfunction

    task automatic drive_idle();
        InALUOut = 0; InFPUOut = 0; InStoreData = 0; InPCPlusFour = 0;
        InOpcode = 0; InFunct = 0; InRegWAddr = 0; InImmediate = 0; InDInSrc = 0;
        InMemSize = 0; InRegWE = 0; InMemRead = 0; InMemWrite = 0; InMemSigned = 0;
    endtask

    // Entered and left just after a rising edge with the stage not stalled.
    task automatic apply(input vec_t v, input string tag);
        logic [31:0] fpu, pc4;
        logic [15:0] imm;
        logic [5:0]  opc, fn, wa;
        logic [1:0]  dsrc;
        fpu = $urandom; pc4 = $urandom; imm = 16'($urandom);
        opc = 6'($urandom); fn = 6'($urandom); wa = 6'($urandom); dsrc = 2'($urandom);
        InALUOut = v.alu; InFPUOut = fpu; InStoreData = v.sdata; InPCPlusFour = pc4;
        InOpcode = opc; InFunct = fn; InRegWAddr = wa; InImmediate = imm; InDInSrc = dsrc;
        InMemSize = v.size; InMemSigned = v.sgn; InRegWE = v.we;
        InMemRead = v.rd; InMemWrite = v.wr;
        DMemAck = 1'b0;
        @(posedge clk); #1;
        drive_idle();
        if (v.req) begin
            for (int i = 0; i <= v.lat; i++) begin
                DMemAck   = (i == v.lat);
                DMemRData = (i == v.lat) ? v.rdata : $urandom;
                @(negedge clk);
                check({tag, ".req"}, DMemReq, 1'b1);
                check({tag, ".busy"}, Busy, (i != v.lat));
                check({tag, ".addr"}, DMemAddr, v.addr);
                if (i == 0) begin
                    check({tag, ".dwe"}, DMemWE, v.dwe);
                    check({tag, ".be"}, DMemBE, v.be);
                    if (v.wr) check({tag, ".wdata"}, DMemWData, v.wdata);
                    check({tag, ".mis"}, MisalignedErr, 1'b0);
                end
                if (i == v.lat) begin
                    check({tag, ".nregwe"}, NextRegWE, v.we);
                    check({tag, ".nopc"}, NextOpcode, opc);
                    check({tag, ".ndout"}, NextMEMDout, v.dout);
                    check({tag, ".nalu"}, NextALUOut, v.alu);
                    check({tag, ".npass"}, {NextFunct, NextRegWAddr, NextDInSrc, NextImmediate},
                          {fn, wa, dsrc, imm});
                    check({tag, ".nfpu"}, NextFPUOut, fpu);
                    check({tag, ".npc4"}, NextPCPlusFour, pc4);
                end else begin
                    check({tag, ".bub_we"}, NextRegWE, 1'b0);
                    check({tag, ".bub_opc"}, NextOpcode, 6'h15);
                end
                @(posedge clk); #1;
            end
            DMemAck = 1'b0;
        end else begin
            @(negedge clk);
            check({tag, ".req"}, DMemReq, 1'b0);
            check({tag, ".busy"}, Busy, 1'b0);
            check({tag, ".mis"}, MisalignedErr, v.mis);
            check({tag, ".nregwe"}, NextRegWE, v.we & ~v.mis);
            check({tag, ".nalu"}, NextALUOut, v.alu);
            check({tag, ".nopc"}, NextOpcode, opc);
            check({tag, ".ndout"}, NextMEMDout, 32'h0);
            @(posedge clk); #1;
            if (v.mis) begin
                @(negedge clk);
                check({tag, ".mis_end"}, MisalignedErr, 1'b0);
                check({tag, ".req_end"}, DMemReq, 1'b0);
                @(posedge clk); #1;
            end
        end
    endtask

    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //            alu          sdata        sz sg rd wr we rdata        lat mis req dwe addr         be     wdata        dout
        tbl[0]  = mk(32'h0000_0042, 32'h0,       0, 0, 0, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,       4'h0, 32'h0,        32'h0);
        tbl[1]  = mk(32'h0000_1001, 32'h0,       0, 1, 1, 0, 1, 32'h11F2_3344, 3, 0, 1, 0, 32'h1000,    4'hF, 32'h0,        32'hFFFF_FFF2);
        tbl[2]  = mk(32'h0000_1002, 32'h0,       1, 0, 1, 0, 1, 32'h11F2_3344, 0, 0, 1, 0, 32'h1000,    4'hF, 32'h0,        32'h0000_3344);
        tbl[3]  = mk(32'h0000_2003, 32'h0000_00AB, 0, 0, 0, 1, 0, 32'h0,      1, 0, 1, 1, 32'h2000,    4'h1, 32'hABAB_ABAB, 32'h0);
        tbl[4]  = mk(32'h0000_2004, 32'hDEAD_BEEF, 2, 0, 0, 1, 0, 32'h0,      0, 0, 1, 1, 32'h2004,    4'hF, 32'hDEAD_BEEF, 32'h0);
        tbl[5]  = mk(32'h0000_3002, 32'h0,       2, 0, 1, 0, 1, 32'h0,        0, 1, 0, 0, 32'h0,       4'h0, 32'h0,        32'h0);
        tbl[6]  = mk(32'h0000_2002, 32'h5555_1234, 1, 0, 0, 1, 0, 32'h0,      2, 0, 1, 1, 32'h2000,    4'h3, 32'h1234_1234, 32'h0);
        tbl[7]  = mk(32'h0000_1000, 32'h0,       1, 1, 1, 0, 1, 32'h8001_7F00, 1, 0, 1, 0, 32'h1000,    4'hF, 32'h0,        32'hFFFF_8001);
        tbl[8]  = mk(32'h0000_1000, 32'h0,       0, 0, 1, 0, 1, 32'hF000_0000, 0, 0, 1, 0, 32'h1000,    4'hF, 32'h0,        32'h0000_00F0);
        tbl[9]  = mk(32'h0000_2001, 32'h0,       1, 0, 0, 1, 0, 32'h0,        0, 1, 0, 0, 32'h0,       4'h0, 32'h0,        32'h0);
        tbl[10] = mk(32'h0000_2000, 32'h0000_0012, 0, 0, 0, 1, 0, 32'h0,      0, 0, 1, 1, 32'h2000,    4'h8, 32'h1212_1212, 32'h0);
        tbl[11] = mk(32'h0000_1002, 32'h0,       1, 1, 1, 0, 1, 32'h0000_7FFF, 2, 0, 1, 0, 32'h1000,    4'hF, 32'h0,        32'h0000_7FFF);

        drive_idle();
        DMemAck = 1'b0; DMemRData = 32'h0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("rst.req", DMemReq, 1'b0);
        check("rst.busy", Busy, 1'b0);
        check("rst.we", DMemWE, 1'b0);
        check("rst.be", DMemBE, 4'h0);
        check("rst.mis", MisalignedErr, 1'b0);
        check("rst.nregwe", NextRegWE, 1'b0);
        check("rst.nopc", NextOpcode, 6'h15);
        check("rst.nalu", NextALUOut, 32'h0);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 200; i++) begin
            int typ;
            typ     = $urandom_range(0, 2);
            v.alu   = $urandom;
            v.sdata = $urandom;
            v.rdata = $urandom;
            v.size  = 2'($urandom_range(0, 2));
            v.sgn   = 1'($urandom);
            v.we    = 1'($urandom);
            v.rd    = (typ == 1);
            v.wr    = (typ == 2);
            v.lat   = $urandom_range(0, 3);
            apply(model(v), $sformatf("rnd%0d", i));
        end

        // Reset while an access is outstanding and never acknowledged.
        InALUOut = 32'h0000_1001; InMemRead = 1'b1; InMemSize = 2'd0; InRegWE = 1'b1;
        InOpcode = 6'h20;
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check("rsta.req_before", DMemReq, 1'b1);
        check("rsta.busy_before", Busy, 1'b1);
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        check("rsta.req", DMemReq, 1'b0);
        check("rsta.busy", Busy, 1'b0);
        check("rsta.nopc", NextOpcode, 6'h15);
        check("rsta.nregwe", NextRegWE, 1'b0);
        check("rsta.be", DMemBE, 4'h0);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        apply(tbl[0], "post_rst_alu");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
